// File: rtl/vram_rect_fill_if.sv
// Fill-command channel (valid/ready plus abort) and VRAM write port of the rectangle-fill engine.
// master drives commands and observes writes; slave is the engine side.
interface vram_rect_fill_if #(
    parameter int C_COORD_WIDTH = 6,
    parameter int C_DATA_WIDTH  = 8
);
    logic                            cmd_valid;
    logic                            cmd_ready;
    logic        [C_COORD_WIDTH-1:0] cmd_x0;
    logic        [C_COORD_WIDTH-1:0] cmd_y0;
    logic        [C_COORD_WIDTH-1:0] cmd_w_m1;
    logic        [C_COORD_WIDTH-1:0] cmd_h_m1;
    logic        [C_DATA_WIDTH-1:0]  cmd_color;
    logic                            cmd_sync;
    logic                            abort;
    logic signed [31:0]              data_address;
    logic signed [C_DATA_WIDTH-1:0]  data_din;
    logic                            data_we;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_w_m1, cmd_h_m1, cmd_color, cmd_sync, abort,
        input  cmd_ready, data_address, data_din, data_we
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_w_m1, cmd_h_m1, cmd_color, cmd_sync, abort,
        output cmd_ready, data_address, data_din, data_we
    );
endinterface

// File: rtl/vram_rect_fill.sv
// Rectangle fill into the 64x64 VRAM: one registered cell write per clock, first write the cycle after accept
// (or after the vsync falling edge); one command at a time, cmd_ready only in IDLE.
module vram_rect_fill #(
    parameter int C_COORD_WIDTH = 6,
    parameter int C_DATA_WIDTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    vram_rect_fill_if.slave   bus,
    input  logic              vsync,
    output logic              busy,
    output logic              done
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_VS = 2'd1;
    localparam logic [1:0] S_FILL    = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]               state;
    logic [C_COORD_WIDTH-1:0] x0_q, y0_q, w_m1_q, h_m1_q;
    logic [C_DATA_WIDTH-1:0]  color_q;
    logic [C_COORD_WIDTH-1:0] i_cnt, j_cnt, i_nxt, j_nxt;
    logic                     vsync_d;
    logic                     row_end, last_cell, vs_fall, accept;

    function automatic logic signed [31:0] cell_addr(input logic [C_COORD_WIDTH-1:0] x,
                                                     input logic [C_COORD_WIDTH-1:0] y);
        logic [31:0] a;
        a = '0;
        a[2*C_COORD_WIDTH-1:0] = {y, x};
        return signed'(a);
    endfunction

    assign bus.cmd_ready = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);

    assign accept    = bus.cmd_valid && (state == S_IDLE);
    assign row_end   = (i_cnt == w_m1_q);
    assign last_cell = row_end && (j_cnt == h_m1_q);
    assign vs_fall   = vsync_d && !vsync;

    always_comb begin
        i_nxt = i_cnt + C_COORD_WIDTH'(1);
        j_nxt = j_cnt;
        if (row_end) begin
            i_nxt = '0;
            j_nxt = j_cnt + C_COORD_WIDTH'(1);
        end
    end

    // The output registers always hold the cell addressed by (i_cnt, j_cnt) while in FILL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            x0_q             <= '0;
            y0_q             <= '0;
            w_m1_q           <= '0;
            h_m1_q           <= '0;
            color_q          <= '0;
            i_cnt            <= '0;
            j_cnt            <= '0;
            vsync_d          <= 1'b1;
            bus.data_we      <= 1'b0;
            bus.data_address <= '0;
            bus.data_din     <= '0;
        end else begin
            vsync_d <= vsync;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        x0_q    <= bus.cmd_x0;
                        y0_q    <= bus.cmd_y0;
                        w_m1_q  <= bus.cmd_w_m1;
                        h_m1_q  <= bus.cmd_h_m1;
                        color_q <= bus.cmd_color;
                        i_cnt   <= '0;
                        j_cnt   <= '0;
                        if (bus.cmd_sync) begin
                            state <= S_WAIT_VS;
                        end else begin
                            state            <= S_FILL;
                            bus.data_we      <= 1'b1;
                            bus.data_address <= cell_addr(bus.cmd_x0, bus.cmd_y0);
                            bus.data_din     <= signed'(bus.cmd_color);
                        end
                    end
                end
                S_WAIT_VS: begin
                    if (bus.abort) begin
                        state <= S_IDLE;
                    end else if (vs_fall) begin
                        state            <= S_FILL;
                        bus.data_we      <= 1'b1;
                        bus.data_address <= cell_addr(x0_q, y0_q);
                        bus.data_din     <= signed'(color_q);
                    end
                end
                S_FILL: begin
                    if (bus.abort) begin
                        state       <= S_IDLE;
                        bus.data_we <= 1'b0;
                    end else if (last_cell) begin
                        state       <= S_DONE;
                        bus.data_we <= 1'b0;
                    end else begin
                        i_cnt            <= i_nxt;
                        j_cnt            <= j_nxt;
                        bus.data_address <= cell_addr(x0_q + i_nxt, y0_q + j_nxt);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_rect_fill.sv
// Directed bench for vram_rect_fill: write order, wrap, vsync gating, abort, reset and back-to-back timing.
module tb_vram_rect_fill;
    logic clk;
    logic rst_n;
    logic vsync;
    logic busy;
    logic done;

    vram_rect_fill_if #(.C_COORD_WIDTH(6), .C_DATA_WIDTH(8)) bus ();

    vram_rect_fill #(.C_COORD_WIDTH(6), .C_DATA_WIDTH(8)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus),
        .vsync (vsync),
        .busy  (busy),
        .done  (done)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int acc = 0;
    logic signed [31:0] wq[$];
    logic signed [7:0]  dq[$];
    int                 wc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.data_we === 1'b1) begin
            wq.push_back(bus.data_address);
            dq.push_back(bus.data_din);
            wc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic clear_mon();
        wq.delete();
        dq.delete();
        wc.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic set_cmd(input logic [5:0] x0, input logic [5:0] y0, input logic [5:0] w,
                           input logic [5:0] h, input logic [7:0] c, input logic s);
        bus.cmd_x0    = x0;
        bus.cmd_y0    = y0;
        bus.cmd_w_m1  = w;
        bus.cmd_h_m1  = h;
        bus.cmd_color = c;
        bus.cmd_sync  = s;
    endtask

    // Presents a command and returns #1 after the accepting edge; acc holds that edge's cycle.
    task automatic send_cmd(input logic [5:0] x0, input logic [5:0] y0, input logic [5:0] w,
                            input logic [5:0] h, input logic [7:0] c, input logic s);
        @(posedge clk);
        #1;
        set_cmd(x0, y0, w, h, c, s);
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.cmd_ready) break;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.cmd_ready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        checks++; if (bus.data_we !== 1'b0) $display("FAIL reset_we got %b want 0", bus.data_we); else passed++;
        checks++; if (bus.data_address !== 32'sd0) $display("FAIL reset_addr got %h want 0", bus.data_address); else passed++;
        checks++; if (bus.data_din !== 8'sd0) $display("FAIL reset_din got %h want 0", bus.data_din); else passed++;
    endtask

    task automatic test_single_cell();
        clear_mon();
        send_cmd(6'd5, 6'd3, 6'd0, 6'd0, 8'hE0, 1'b0);
        repeat (6) @(posedge clk);
        checks++; if (wq.size() !== 1) $display("FAIL single_count got %0d want 1", wq.size()); else passed++;
        if (wq.size() > 0) begin
            checks++; if (wq[0] !== 32'h0C5) $display("FAIL single_addr got %h want 0c5", wq[0]); else passed++;
            checks++; if (dq[0] !== 8'hE0) $display("FAIL single_data got %h want e0", dq[0]); else passed++;
            checks++; if (wc[0] !== acc) $display("FAIL single_first_cyc got %0d want %0d", wc[0], acc); else passed++;
        end
        checks++; if (done_cnt !== 1) $display("FAIL single_done_cnt got %0d want 1", done_cnt); else passed++;
        checks++; if (done_cyc !== acc + 1) $display("FAIL single_done_cyc got %0d want %0d", done_cyc, acc + 1); else passed++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr [6];
        exp_addr = '{32'hFFE, 32'hFFF, 32'hFC0, 32'h03E, 32'h03F, 32'h000};
        clear_mon();
        send_cmd(6'd62, 6'd63, 6'd2, 6'd1, 8'h1C, 1'b0);
        repeat (10) @(posedge clk);
        checks++; if (wq.size() !== 6) $display("FAIL wrap_count got %0d want 6", wq.size()); else passed++;
        for (int k = 0; k < 6 && k < wq.size(); k++) begin
            checks++;
            if (wq[k] !== exp_addr[k]) $display("FAIL wrap_addr%0d got %h want %h", k, wq[k], exp_addr[k]);
            else passed++;
        end
        checks++; if (done_cyc !== acc + 6) $display("FAIL wrap_done_cyc got %0d want %0d", done_cyc, acc + 6); else passed++;
    endtask

    task automatic test_vsync_gating();
        int bad;
        int fall_edge;
        bad = 0;
        clear_mon();
        send_cmd(6'd1, 6'd1, 6'd1, 6'd0, 8'h03, 1'b1);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.data_we !== 1'b0 || busy !== 1'b1) bad++;
        end
        @(posedge clk);
        #1;
        vsync = 1'b0;
        fall_edge = cyc + 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done_cnt == 0 && busy !== 1'b1) bad++;
        end
        vsync = 1'b1;
        checks++; if (bad !== 0) $display("FAIL vsync_hold got %0d bad cycles want 0", bad); else passed++;
        checks++; if (wq.size() !== 2) $display("FAIL vsync_count got %0d want 2", wq.size()); else passed++;
        if (wq.size() > 0) begin
            checks++; if (wc[0] !== fall_edge) $display("FAIL vsync_first_cyc got %0d want %0d", wc[0], fall_edge); else passed++;
            checks++; if (wq[0] !== 32'h041) $display("FAIL vsync_addr got %h want 041", wq[0]); else passed++;
        end
        checks++; if (done_cnt !== 1) $display("FAIL vsync_done_cnt got %0d want 1", done_cnt); else passed++;
    endtask

    task automatic test_full_screen();
        int bad_addr;
        int bad_cyc;
        bad_addr = 0;
        bad_cyc = 0;
        clear_mon();
        send_cmd(6'd0, 6'd0, 6'd63, 6'd63, 8'h55, 1'b0);
        for (int k = 0; k < 5000 && done_cnt == 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        checks++; if (done_cnt !== 1) $display("FAIL full_done_cnt got %0d want 1", done_cnt); else passed++;
        checks++; if (wq.size() !== 4096) $display("FAIL full_count got %0d want 4096", wq.size()); else passed++;
        for (int k = 0; k < wq.size(); k++) begin
            if (wq[k] !== k) bad_addr++;
            if (wc[k] !== acc + k) bad_cyc++;
        end
        checks++; if (bad_addr !== 0) $display("FAIL full_order got %0d wrong addresses want 0", bad_addr); else passed++;
        checks++; if (bad_cyc !== 0) $display("FAIL full_contig got %0d gaps want 0", bad_cyc); else passed++;
        checks++; if (done_cyc !== acc + 4096) $display("FAIL full_done_cyc got %0d want %0d", done_cyc, acc + 4096); else passed++;
    endtask

    task automatic test_abort();
        clear_mon();
        send_cmd(6'd10, 6'd10, 6'd7, 6'd7, 8'hAA, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL abort_ready got %b want 1", bus.cmd_ready); else passed++;
        repeat (80) @(posedge clk);
        checks++; if (wq.size() !== 10) $display("FAIL abort_count got %0d want 10", wq.size()); else passed++;
        checks++; if (done_cnt !== 0) $display("FAIL abort_done got %0d want 0", done_cnt); else passed++;
        clear_mon();
        send_cmd(6'd2, 6'd0, 6'd1, 6'd0, 8'h0F, 1'b0);
        repeat (6) @(posedge clk);
        checks++; if (wq.size() !== 2) $display("FAIL post_abort_count got %0d want 2", wq.size()); else passed++;
        if (wq.size() == 2) begin
            checks++; if (wq[1] !== 32'h003) $display("FAIL post_abort_addr got %h want 003", wq[1]); else passed++;
        end
        checks++; if (done_cnt !== 1) $display("FAIL post_abort_done got %0d want 1", done_cnt); else passed++;
    endtask

    task automatic test_reset_midfill();
        clear_mon();
        send_cmd(6'd0, 6'd20, 6'd7, 6'd7, 8'h77, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.data_we !== 1'b0) $display("FAIL rst_mid_we got %b want 0", bus.data_we); else passed++;
        checks++; if (bus.data_address !== 32'sd0) $display("FAIL rst_mid_addr got %h want 0", bus.data_address); else passed++;
        checks++; if (bus.data_din !== 8'sd0) $display("FAIL rst_mid_din got %h want 0", bus.data_din); else passed++;
        checks++; if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL rst_mid_state got ready=%b busy=%b done=%b want 1 0 0", bus.cmd_ready, busy, done);
        else passed++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        checks++; if (wq.size() !== 5) $display("FAIL rst_mid_count got %0d want 5", wq.size()); else passed++;
        checks++; if (done_cnt !== 0) $display("FAIL rst_mid_done got %0d want 0", done_cnt); else passed++;
    endtask

    task automatic test_back_to_back();
        int acc2;
        acc2 = -1;
        clear_mon();
        @(posedge clk);
        #1;
        set_cmd(6'd4, 6'd4, 6'd2, 6'd0, 8'h11, 1'b0);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        set_cmd(6'd8, 6'd8, 6'd1, 6'd0, 8'h22, 1'b0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.cmd_ready) break;
        end
        @(posedge clk);
        #1;
        acc2 = cyc;
        bus.cmd_valid = 1'b0;
        repeat (8) @(posedge clk);
        checks++; if (wq.size() !== 5) $display("FAIL b2b_count got %0d want 5", wq.size()); else passed++;
        if (wq.size() == 5) begin
            checks++; if (wc[2] !== acc + 2) $display("FAIL b2b_last_a got %0d want %0d", wc[2], acc + 2); else passed++;
            checks++; if (wc[3] - wc[2] !== 3) $display("FAIL b2b_gap got %0d want 3", wc[3] - wc[2]); else passed++;
            checks++; if (wq[3] !== 32'h208) $display("FAIL b2b_addr_b got %h want 208", wq[3]); else passed++;
        end
        checks++; if (acc2 !== acc + 5) $display("FAIL b2b_accept got %0d want %0d", acc2, acc + 5); else passed++;
        checks++; if (done_cnt !== 2) $display("FAIL b2b_done got %0d want 2", done_cnt); else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        vsync = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.abort = 1'b0;
        set_cmd(6'd0, 6'd0, 6'd0, 6'd0, 8'h00, 1'b0);
        test_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_single_cell();
        test_wrap();
        test_vsync_gating();
        test_full_screen();
        test_abort();
        test_reset_midfill();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
